// File: rtl/wb_regfile_stage.sv
// Writeback latch + architectural register file with two async read ports.
// Optional bypass of the uncommitted latch entry: define WB_FWD_EN.
module wb_regfile_stage #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int AW     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AW-1:0]     in_rd,
   input  logic [DATA_W-1:0] in_data,
   input  logic              wb_hold,
   input  logic [AW-1:0]     rd_addr_a,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              hazard,
   output logic              commit
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} st_t;

   st_t                          st, st_nxt;
   logic                         wb_valid;
   logic [AW-1:0]                wb_rd;
   logic [DATA_W-1:0]            wb_data;
   logic [NREG-1:0][DATA_W-1:0]  regs;
   logic                         xfer;

   always_ff @(posedge clk) begin
      if (rst) st <= EMPTY;
      else     st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         EMPTY:   if (xfer) st_nxt = FULL;
         FULL:    if (commit && !xfer) st_nxt = EMPTY;
         default: st_nxt = EMPTY;
      endcase
   end

   always_comb begin
      wb_valid = (st == FULL);
      commit   = wb_valid & ~wb_hold;
      in_ready = ~wb_valid | commit;
      xfer     = in_valid & in_ready;
   end

   // Latch payload only moves on a transfer; a held entry keeps its value.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_rd   <= '0;
         wb_data <= '0;
      end else if (xfer) begin
         wb_rd   <= in_rd;
         wb_data <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         regs        <= '0;
      else if (commit) regs[wb_rd] <= wb_data;
   end

`ifdef WB_FWD_EN
   always_comb begin
      rd_data_a = (wb_valid && rd_addr_a == wb_rd) ? wb_data : regs[rd_addr_a];
      rd_data_b = (wb_valid && rd_addr_b == wb_rd) ? wb_data : regs[rd_addr_b];
      hazard    = 1'b0;
   end
`else
   always_comb begin
      rd_data_a = regs[rd_addr_a];
      rd_data_b = regs[rd_addr_b];
      hazard    = wb_valid & ((rd_addr_a == wb_rd) | (rd_addr_b == wb_rd));
   end
`endif

endmodule
